// File: rtl/xain_pkg.sv
// xain_pkg: shared types and constants for the Xain'd Sleena ROM loader.
//   region_t       - per-region routing: SDRAM base address, or BRAM one-hot select
//   LOAD_REGIONS   - ordered list of regions in the download image
//   loader_state_t - loader FSM states
//   HDR_BYTES      - length-header size in bytes
package xain_pkg;

    typedef struct packed {
        logic [24:0] base_addr;  // SDRAM byte base; word aligned
        logic [5:0]  bram_cs;    // non-zero selects a BRAM, zero selects SDRAM
    } region_t;

    localparam int REGION_COUNT = 10;

    // The last entry is a spare; the loader visits only NUM_REGIONS entries.
    localparam region_t LOAD_REGIONS [REGION_COUNT] = '{
        '{25'h0000000, 6'b000001},  // 0: main CPU work BRAM
        '{25'h0000000, 6'b000010},  // 1: sub CPU BRAM
        '{25'h0000000, 6'b000100},  // 2: sound CPU BRAM
        '{25'h0000000, 6'b001000},  // 3: MCU BRAM
        '{25'h0000000, 6'b010000},  // 4: char ROM BRAM
        '{25'h0000000, 6'b100000},  // 5: PROM BRAM
        '{25'h0040000, 6'b000000},  // 6: main program, SDRAM
        '{25'h0080000, 6'b000000},  // 7: sub program, SDRAM
        '{25'h0100000, 6'b000000},  // 8: graphics, SDRAM
        '{25'h0180000, 6'b000000}   // 9: spare
    };

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        SDR_WAIT,
        FLUSH,
        DONE
    } loader_state_t;

    localparam int HDR_BYTES = 4;

    // Out-of-range indices return an all-zero region rather than indexing past the table.
    function automatic region_t region_lookup(input logic [3:0] idx);
        region_t r;
        r = '0;
        for (int i = 0; i < REGION_COUNT; i++) begin
            if (idx == 4'(i)) r = LOAD_REGIONS[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/xain_sdr_packer.sv
// xain_sdr_packer: packs download bytes into 16-bit SDRAM writes and holds the
// request until acknowledged.
//   clk, reset   - clock, async active-high reset
//   clear        - synchronous clear at the start of a download
//   byte_vld     - accepted byte for an SDRAM region
//   byte_data    - that byte
//   byte_odd     - byte sits at an odd offset (completes a word)
//   word_addr    - SDRAM address of the word holding this byte
//   flush        - write out a pending low byte on its own
//   sdr_*        - SDRAM write request port (level req, one-cycle ack)
//   pending      - a low byte is held waiting for its partner
//   ack_done     - request accepted this cycle
module xain_sdr_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_vld,
    input  logic [7:0]  byte_data,
    input  logic        byte_odd,
    input  logic [24:0] word_addr,
    input  logic        flush,
    input  logic        sdr_ack,
    output logic        sdr_req,
    output logic [24:0] sdr_addr,
    output logic [15:0] sdr_data,
    output logic [1:0]  sdr_be,
    output logic        pending,
    output logic        ack_done
);

    logic [7:0]  lo_byte;
    logic [24:0] lo_addr;

    assign ack_done = sdr_req & sdr_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sdr_req  <= 1'b0;
            sdr_addr <= '0;
            sdr_data <= '0;
            sdr_be   <= '0;
            pending  <= 1'b0;
            lo_byte  <= '0;
            lo_addr  <= '0;
        end else if (clear) begin
            sdr_req  <= 1'b0;
            sdr_addr <= '0;
            sdr_data <= '0;
            sdr_be   <= '0;
            pending  <= 1'b0;
            lo_byte  <= '0;
            lo_addr  <= '0;
        end else if (sdr_req) begin
            // Address/data/be stay frozen while the request is outstanding.
            if (sdr_ack) sdr_req <= 1'b0;
        end else if (byte_vld) begin
            if (!byte_odd) begin
                lo_byte <= byte_data;
                lo_addr <= word_addr;
                pending <= 1'b1;
            end else begin
                sdr_addr <= word_addr;
                sdr_data <= {byte_data, lo_byte};
                sdr_be   <= 2'b11;
                sdr_req  <= 1'b1;
                pending  <= 1'b0;
            end
        end else if (flush && pending) begin
            sdr_addr <= lo_addr;
            sdr_data <= {8'h00, lo_byte};
            sdr_be   <= 2'b01;
            sdr_req  <= 1'b1;
            pending  <= 1'b0;
        end
    end

endmodule

// File: rtl/xain_rom_loader.sv
// xain_rom_loader: walks LOAD_REGIONS, parsing a 4-byte big-endian length per
// region and routing payload bytes to BRAM or (word-packed) to SDRAM.
//   clk, reset                - clock, async active-high reset
//   ioctl_download/wr/data    - HPS download port
//   ioctl_wait                - backpressure while an SDRAM write is in flight
//   bram_addr/data/cs/wr      - BRAM byte write port, one-cycle strobe
//   sdr_addr/data/be/req/ack  - SDRAM word write port
//   load_done                 - all regions loaded or download ended
//   cur_region                - region index being loaded (debug)
module xain_rom_loader #(
    parameter int NUM_REGIONS = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_data,
    output logic        ioctl_wait,
    output logic [24:0] bram_addr,
    output logic [7:0]  bram_data,
    output logic [5:0]  bram_cs,
    output logic        bram_wr,
    output logic [24:0] sdr_addr,
    output logic [15:0] sdr_data,
    output logic [1:0]  sdr_be,
    output logic        sdr_req,
    input  logic        sdr_ack,
    output logic        load_done,
    output logic [3:0]  cur_region
);
    import xain_pkg::*;

    loader_state_t state, state_next;

    logic        dl_q;
    logic [1:0]  hdr_cnt;
    // Only the low 25 bits of the header matter, so keep just the last 17 bits
    // of the shifted stream; the 4th byte supplies the remaining 8.
    logic [16:0] hdr_sr;
    logic [24:0] hdr_len;
    logic [24:0] len;
    logic [24:0] offset;
    logic        at_end;
    logic        ending;

    region_t     region;
    logic        is_bram;
    logic        last;
    logic        rise;
    logic        wr_ok;
    logic [24:0] word_addr;

    logic        start, hdr_take, data_take, adv, flush;
    logic        pk_pending, pk_ack_done;

    assign region    = region_lookup(cur_region);
    assign is_bram   = (region.bram_cs != 6'd0);
    assign last      = ((offset + 25'd1) == len);
    assign rise      = ioctl_download & ~dl_q;
    assign hdr_len   = {hdr_sr, ioctl_data};
    assign word_addr = region.base_addr + {offset[24:1], 1'b0};

    // FLUSH is covered too so a header byte of the next region can't slip in
    // during the one cycle before the flush request rises.
    assign ioctl_wait = sdr_req | (state == FLUSH);
    assign wr_ok      = ioctl_wr & ~ioctl_wait;

    always_comb begin
        state_next = state;
        start      = 1'b0;
        hdr_take   = 1'b0;
        data_take  = 1'b0;
        adv        = 1'b0;
        flush      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (rise) begin
                    start      = 1'b1;
                    state_next = HDR;
                end
            end
            HDR: begin
                if (!ioctl_download) begin
                    state_next = DONE;
                end else if (wr_ok) begin
                    hdr_take = 1'b1;
                    if (hdr_cnt == 2'(HDR_BYTES - 1)) begin
                        if (hdr_len == 25'd0) adv = 1'b1;
                        else                  state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (!ioctl_download) begin
                    state_next = pk_pending ? FLUSH : DONE;
                end else if (wr_ok) begin
                    data_take = 1'b1;
                    if (!is_bram && offset[0]) begin
                        state_next = SDR_WAIT;
                    end else if (last) begin
                        if (!is_bram) state_next = FLUSH;  // even byte ends the region
                        else          adv = 1'b1;
                    end
                end
            end
            SDR_WAIT: begin
                if (pk_ack_done) begin
                    if (ending)      state_next = DONE;
                    else if (at_end) adv = 1'b1;
                    else             state_next = DATA;
                end
            end
            FLUSH: begin
                flush      = 1'b1;
                state_next = SDR_WAIT;
            end
            default: state_next = IDLE;
        endcase
        if (adv) begin
            state_next = (cur_region == 4'(NUM_REGIONS - 1)) ? DONE : HDR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dl_q       <= 1'b0;
            hdr_cnt    <= '0;
            hdr_sr     <= '0;
            len        <= '0;
            offset     <= '0;
            at_end     <= 1'b0;
            ending     <= 1'b0;
            cur_region <= '0;
            load_done  <= 1'b0;
            bram_wr    <= 1'b0;
            bram_addr  <= '0;
            bram_data  <= '0;
            bram_cs    <= '0;
        end else begin
            state   <= state_next;
            dl_q    <= ioctl_download;
            bram_wr <= 1'b0;

            if (start) begin
                cur_region <= '0;
                hdr_cnt    <= '0;
                offset     <= '0;
                at_end     <= 1'b0;
                ending     <= 1'b0;
                load_done  <= 1'b0;
            end

            if (hdr_take) begin
                hdr_sr  <= {hdr_sr[8:0], ioctl_data};
                hdr_cnt <= hdr_cnt + 2'd1;
                if (hdr_cnt == 2'(HDR_BYTES - 1)) begin
                    len    <= hdr_len;
                    offset <= '0;
                end
            end

            if (data_take) begin
                offset <= offset + 25'd1;
                at_end <= last;
                if (is_bram) begin
                    bram_wr   <= 1'b1;
                    bram_addr <= offset;
                    bram_data <= ioctl_data;
                    bram_cs   <= region.bram_cs;
                end
            end

            // Remembered so the flush that follows an early end lands in DONE.
            if (state == DATA && !ioctl_download) ending <= 1'b1;

            if (adv) begin
                cur_region <= cur_region + 4'd1;
                hdr_cnt    <= '0;
            end

            if (state_next == DONE) load_done <= 1'b1;
        end
    end

    xain_sdr_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start),
        .byte_vld  (data_take & ~is_bram),
        .byte_data (ioctl_data),
        .byte_odd  (offset[0]),
        .word_addr (word_addr),
        .flush     (flush),
        .sdr_ack   (sdr_ack),
        .sdr_req   (sdr_req),
        .sdr_addr  (sdr_addr),
        .sdr_data  (sdr_data),
        .sdr_be    (sdr_be),
        .pending   (pk_pending),
        .ack_done  (pk_ack_done)
    );

endmodule

// File: tb/tb_xain_rom_loader.sv
// Scoreboard bench for xain_rom_loader: expected BRAM/SDRAM writes are queued
// as bytes are issued; a monitor pops and compares on every DUT write.
module tb_xain_rom_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download, ioctl_wr, ioctl_wait;
    logic [7:0]  ioctl_data;
    logic [24:0] bram_addr, sdr_addr;
    logic [7:0]  bram_data;
    logic [5:0]  bram_cs;
    logic        bram_wr, sdr_req, sdr_ack, load_done;
    logic [15:0] sdr_data;
    logic [1:0]  sdr_be;
    logic [3:0]  cur_region;

    always #5 clk = ~clk;

    xain_rom_loader #(.NUM_REGIONS(9)) dut (
        .clk(clk), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_data(ioctl_data),
        .ioctl_wait(ioctl_wait),
        .bram_addr(bram_addr), .bram_data(bram_data), .bram_cs(bram_cs), .bram_wr(bram_wr),
        .sdr_addr(sdr_addr), .sdr_data(sdr_data), .sdr_be(sdr_be), .sdr_req(sdr_req),
        .sdr_ack(sdr_ack), .load_done(load_done), .cur_region(cur_region)
    );

    typedef struct { logic [5:0] cs; logic [24:0] addr; logic [7:0] data; } bram_exp_t;
    typedef struct { logic [24:0] addr; logic [15:0] data; logic [1:0] be; } sdr_exp_t;

    bram_exp_t bq[$];
    sdr_exp_t  sq[$];
    bram_exp_t be_e;
    sdr_exp_t  se_e;

    int n_cmp = 0, n_err = 0;
    int ack_delay = 1, ack_cnt = 0;
    int wait_run = 0, last_wait_len = 0;
    int done_rises = 0;
    logic done_q = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every write the DUT presents against the queues.
    always @(negedge clk) begin
        if (bram_wr) begin
            if (bq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL bram_unexpected: got write addr %0h data %0h, expected none", bram_addr, bram_data);
            end else begin
                be_e = bq.pop_front();
                check("bram_cs", 32'(bram_cs), 32'(be_e.cs));
                check("bram_addr", 32'(bram_addr), 32'(be_e.addr));
                check("bram_data", 32'(bram_data), 32'(be_e.data));
            end
        end
        if (sdr_req && sdr_ack) begin
            if (sq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL sdr_unexpected: got write addr %0h data %0h, expected none", sdr_addr, sdr_data);
            end else begin
                se_e = sq.pop_front();
                check("sdr_addr", 32'(sdr_addr), 32'(se_e.addr));
                check("sdr_data", 32'(sdr_data), 32'(se_e.data));
                check("sdr_be", 32'(sdr_be), 32'(se_e.be));
            end
        end
        if (ioctl_wait) wait_run++;
        else if (wait_run != 0) begin
            last_wait_len = wait_run;
            wait_run = 0;
        end
        if (load_done && !done_q) done_rises++;
        done_q = load_done;
    end

    // SDRAM arbiter model: ack after req has been seen for ack_delay+1 cycles.
    initial begin
        sdr_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            sdr_ack = 1'b0;
            if (sdr_req) begin
                ack_cnt++;
                if (ack_cnt > ack_delay) begin
                    sdr_ack = 1'b1;
                    ack_cnt = 0;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        while (ioctl_wait && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (ioctl_wait) begin
            n_cmp++; n_err++;
            $display("FAIL wait_timeout: ioctl_wait got 1, expected 0");
        end
        ioctl_data = b;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] v);
        send_byte(v[31:24]);
        send_byte(v[23:16]);
        send_byte(v[15:8]);
        send_byte(v[7:0]);
    endtask

    task automatic exp_bram(input logic [5:0] cs, input logic [24:0] a, input logic [7:0] d);
        bram_exp_t e;
        e.cs = cs; e.addr = a; e.data = d;
        bq.push_back(e);
    endtask

    task automatic exp_sdr(input logic [24:0] a, input logic [15:0] d, input logic [1:0] be);
        sdr_exp_t e;
        e.addr = a; e.data = d; e.be = be;
        sq.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (!load_done && t < 100) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(load_done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_data = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_bram_wr", 32'(bram_wr), 0);
        check("rst_bram_addr", 32'(bram_addr), 0);
        check("rst_bram_cs", 32'(bram_cs), 0);
        check("rst_sdr_req", 32'(sdr_req), 0);
        check("rst_sdr_addr", 32'(sdr_addr), 0);
        check("rst_sdr_be", 32'(sdr_be), 0);
        check("rst_ioctl_wait", 32'(ioctl_wait), 0);
        check("rst_load_done", 32'(load_done), 0);
        check("rst_cur_region", 32'(cur_region), 0);
        reset = 1'b0;
        @(negedge clk);

        // Region walk, odd length, backpressure, full load
        ioctl_download = 1'b1;
        @(negedge clk);
        done_rises = 0;
        send_hdr(32'h00000004);
        for (int i = 0; i < 4; i++) exp_bram(6'b000001, 25'(i), 8'hB0 + 8'(i));
        for (int i = 0; i < 4; i++) send_byte(8'hB0 + 8'(i));
        for (int r = 1; r <= 5; r++) send_hdr(32'h0);
        // Bits 31:25 of the header are ignored
        send_hdr(32'hFE000006);
        exp_sdr(25'h0040000, 16'hA1A0, 2'b11);
        exp_sdr(25'h0040002, 16'hA3A2, 2'b11);
        exp_sdr(25'h0040004, 16'hA5A4, 2'b11);
        send_byte(8'hA0);
        send_byte(8'hA1);
        send_byte(8'hA2);
        ack_delay = 5;
        send_byte(8'hA3);
        check("bp_wait_high", 32'(ioctl_wait), 1);
        ioctl_data = 8'hEE;
        ioctl_wr = 1'b1;
        @(negedge clk);
        ioctl_wr = 1'b0;
        send_byte(8'hA4);
        ack_delay = 1;
        check("bp_wait_len", 32'(last_wait_len), 6);
        send_byte(8'hA5);
        send_hdr(32'h00000003);
        check("region7_index", 32'(cur_region), 7);
        exp_sdr(25'h0080000, 16'h2211, 2'b11);
        exp_sdr(25'h0080002, 16'h0033, 2'b01);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("not_done_yet", 32'(load_done), 0);
        send_hdr(32'h00000002);
        exp_sdr(25'h0100000, 16'hC1C0, 2'b11);
        send_byte(8'hC0);
        send_byte(8'hC1);
        wait_done("full_load_done");
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        repeat (5) @(negedge clk);
        check("done_rises_once", 32'(done_rises), 1);
        check("walk_bram_drained", 32'(bq.size()), 0);
        check("walk_sdr_drained", 32'(sq.size()), 0);
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk);
        check("done_holds", 32'(load_done), 1);

        // Early end after one byte of an SDRAM region
        ioctl_download = 1'b1;
        @(negedge clk);
        check("restart_clears_done", 32'(load_done), 0);
        for (int r = 0; r <= 5; r++) send_hdr(32'h0);
        send_hdr(32'h00000004);
        exp_sdr(25'h0040000, 16'h005A, 2'b01);
        send_byte(8'h5A);
        ioctl_download = 1'b0;
        wait_done("early_end_done");
        repeat (2) @(negedge clk);
        check("early_sdr_drained", 32'(sq.size()), 0);

        // Reset during SDR_WAIT
        ioctl_download = 1'b1;
        @(negedge clk);
        for (int r = 0; r <= 5; r++) send_hdr(32'h0);
        send_hdr(32'h00000002);
        ack_delay = 50;
        send_byte(8'h01);
        send_byte(8'h02);
        check("pre_reset_req", 32'(sdr_req), 1);
        #1;
        reset = 1'b1;
        #1;
        check("reset_async_req", 32'(sdr_req), 0);
        check("reset_wait", 32'(ioctl_wait), 0);
        check("reset_load_done", 32'(load_done), 0);
        ioctl_download = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        ack_delay = 1;
        @(negedge clk);
        ioctl_download = 1'b1;
        @(negedge clk);
        check("restart_region", 32'(cur_region), 0);
        exp_bram(6'b000001, 25'h0, 8'h77);
        exp_bram(6'b000001, 25'h1, 8'h88);
        send_hdr(32'h00000002);
        send_byte(8'h77);
        send_byte(8'h88);
        repeat (3) @(negedge clk);
        check("restart_next_region", 32'(cur_region), 1);
        check("restart_bram_drained", 32'(bq.size()), 0);
        check("restart_sdr_drained", 32'(sq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xain_rom_loader.md
# xain_rom_loader

Streaming ROM loader between the HPS `ioctl` download port and the game's memories. Walks the `xain_pkg::LOAD_REGIONS` list in order, parses a 4-byte length header per region, and routes each payload byte to on-chip BRAM, selected by the region's `bram_cs`, or packs bytes into 16-bit words for SDRAM at `base_addr + offset`. Asserts `ioctl_wait` as backpressure while an SDRAM write is outstanding, and flags completion to the core reset logic.

## Interface
- `NUM_REGIONS`, 9 — entries of `LOAD_REGIONS` consumed; regions beyond this are never visited.
- `clk` in 1 — system clock; single clock domain.
- `reset` in 1 — asynchronous, active-high.
- `ioctl_download` in 1 — high for the whole ROM download.
- `ioctl_wr` in 1 — one-cycle strobe; one valid byte on `ioctl_data`.
- `ioctl_data` in 8 — download byte.
- `ioctl_wait` out 1 — backpressure; the HPS issues no `ioctl_wr` while this is high.
- `bram_addr` out 25 — byte offset within the current region.
- `bram_data` out 8 — byte to write.
- `bram_cs` out 6 — one-hot BRAM select, copied from the region.
- `bram_wr` out 1 — one-cycle write strobe.
- `sdr_addr` out 25 — SDRAM byte address; bit 0 is always 0.
- `sdr_data` out 16 — packed word; even byte in `[7:0]`, odd byte in `[15:8]`.
- `sdr_be` out 2 — byte enables.
- `sdr_req` out 1 — write request, level.
- `sdr_ack` in 1 — one-cycle acknowledge from the SDRAM arbiter.
- `load_done` out 1 — all regions loaded, or download ended.
- `cur_region` out 4 — index of the region being loaded; debug only.

## Operation
- **States:** IDLE, HDR, DATA, SDR_WAIT, FLUSH, DONE.
- **IDLE:**
  - Waits for a rising edge of `ioctl_download`.
  - On that edge: `cur_region=0`, header byte counter=0, `load_done=0`, then go to HDR.
- **HDR:**
  - Each `ioctl_wr` shifts `ioctl_data` into a 32-bit big-endian length.
  - After the 4th byte, `len = hdr[24:0]`; bits 31:25 are ignored. Clear `offset`.
  - `len==0`: advance the region and stay in HDR.
  - Otherwise go to DATA.
- **DATA, BRAM region** (`bram_cs != 0`):
  - Each byte produces a `bram_wr` pulse with `bram_addr=offset`, `bram_data=byte`, `bram_cs=region.bram_cs`.
  - `offset` increments by 1.
- **DATA, SDRAM region** (`bram_cs == 0`):
  - Even-offset byte: latched in the low half; no request yet.
  - Odd-offset byte: completes the word. `sdr_addr = base_addr + {offset[24:1],1'b0}`, `sdr_be=2'b11`, `sdr_req=1`, go to SDR_WAIT.
- **Region end:** when `offset+1 == len` on a byte:
  - If an SDRAM low byte is pending, go to FLUSH.
  - Otherwise advance the region.
- **Advance region:** `cur_region+1`.
  - If the result equals `NUM_REGIONS`, go to DONE.
  - Otherwise go to HDR.
- **SDR_WAIT:** hold `sdr_req` and the address/data until `sdr_ack` is sampled high. Then drop `sdr_req` and return to DATA, or advance the region if at region end.
- **FLUSH:** issue a single request with `sdr_be=2'b01` and `sdr_data[15:8]=0`, then continue as SDR_WAIT.
- **Download ends early:** on a falling edge of `ioctl_download` in HDR/DATA:
  - Pending low byte → FLUSH, then DONE.
  - Otherwise go directly to DONE.
- **DONE:**
  - `load_done=1` and all bytes are ignored.
  - A new rising edge of `ioctl_download` restarts as in IDLE.
- **Out-of-protocol input:** an `ioctl_wr` arriving while `ioctl_wait=1` is dropped and not counted.

## Timing
- **Reset values:** every output 0; state=IDLE.
- **BRAM write:** `bram_wr` is high exactly one cycle, on the cycle after `ioctl_wr` is sampled. Address, data and cs are valid in that same cycle.
- **SDRAM request:** `sdr_req` rises the cycle after the odd byte's `ioctl_wr`.
  - Falls the cycle after `sdr_ack` is sampled; minimum high time is 1 cycle.
  - `ioctl_wait` follows the same timing as `sdr_req`.
- **Throughput:**
  - BRAM: one byte per cycle.
  - SDRAM: limited only by ack latency.
- **load_done:** asserts the cycle after the last write completes (the last `bram_wr` cycle, or the cycle after the last `sdr_ack`).
- **Reset mid-operation:** returns to IDLE immediately. `sdr_req` drops asynchronously and the partial word is discarded.

## Structure
- `region_t` and `LOAD_REGIONS` stay in `xain_pkg`.
- Add to `xain_pkg`:
  - the state enum `loader_state_t`;
  - `HDR_BYTES = 4`.
- Sub-module `xain_sdr_packer`: byte→word packing, flush and the req/ack hold. The loader FSM handles parsing and region sequencing.

## Test plan
- **Region walk:** headers `00000004` for region 0, then `0` for regions 1–5, then 6 bytes `A0..A5` for region 6 → four `bram_wr` with `cs=000001` at addr 0..3. SDRAM words `A1A0@0x40000`, `A3A2@0x40002`, `A5A4@0x40004`. `cur_region` ends at 7.
- **Odd length:** region 7 length 3, bytes `11 22 33` → `2211@0x80000` with be `11`, then `0033@0x80002` with be `01`.
- **Backpressure:** ack delayed 5 cycles → `ioctl_wait` high for 6 cycles. An `ioctl_wr` injected during wait is dropped, and the next word is unaffected.
- **Early end:** `ioctl_download` falls after 1 byte of an SDRAM region → flush with be `01`, then `load_done=1`.
- **Reset mid-op:** reset during SDR_WAIT → `sdr_req` goes 0 immediately and `load_done=0`. A new download restarts at region 0, offset 0.
- **Full load:** all 9 regions loaded → `load_done` rises exactly once. Trailing bytes produce no writes.
